// File: rtl/echo_detector.sv
// echo_detector: blanks transmitter ring-down after a trigger, then strobes once when the
// rectified sample stays above threshold. Define ECHO_ENVELOPE_EN to compare a smoothed envelope instead.
module echo_detector #(
    parameter int unsigned SAMPLE_WIDTH  = 12,
    parameter int unsigned BLANK_CYCLES  = 20000,
    parameter int unsigned WINDOW_CYCLES = 500000,
    parameter int unsigned CONFIRM_COUNT = 4,
    parameter int unsigned ENV_SHIFT     = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    trigger_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic [SAMPLE_WIDTH-2:0] threshold_in,
    output logic                    echo_detected,
    output logic [SAMPLE_WIDTH-2:0] peak_out,
    output logic                    busy_out
);

    localparam int unsigned MW    = SAMPLE_WIDTH - 1;
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned RUN_W = $clog2(CONFIRM_COUNT + 1);
    localparam logic [SAMPLE_WIDTH-1:0] MID = {1'b1, {MW{1'b0}}};

    if (CONFIRM_COUNT < 1 || ENV_SHIFT >= MW) begin : g_param_check
        $error("echo_detector: CONFIRM_COUNT must be >= 1 and ENV_SHIFT < SAMPLE_WIDTH-1");
    end

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN} state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    mag, qval, thr_q, peak_q;
    logic [WIN_W-1:0] win_q;
    logic [RUN_W-1:0] run_q;
    logic             qual, above, hit, timeout, start;
    logic             cool_q, echo_q, busy_q;

    // |sample - midscale|; sample 0 would need one extra bit, so it saturates
    always_comb begin
        mag = '0;
        if (sample_in[MW])
            mag = sample_in[MW-1:0];
        else if (sample_in == '0)
            mag = '1;
        else
            mag = MW'(MID - sample_in);
    end

`ifdef ECHO_ENVELOPE_EN
    logic [MW-1:0] env_q, env_next;
    logic          env_vld_q;

    assign env_next = env_q - (env_q >> ENV_SHIFT) + (mag >> ENV_SHIFT);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            env_q     <= '0;
            env_vld_q <= 1'b0;
        end else if (start) begin
            env_q     <= '0;
            env_vld_q <= 1'b0;
        end else begin
            env_vld_q <= (state_q == LISTEN) && sample_valid_in;
            if ((state_q == LISTEN) && sample_valid_in)
                env_q <= env_next;
        end
    end

    // Envelope is compared the cycle after it absorbs a sample
    assign qual = (state_q == LISTEN) && env_vld_q;
    assign qval = env_q;
`else
    assign qual = (state_q == LISTEN) && sample_valid_in;
    assign qval = mag;
`endif

    // cool_q blocks a trigger in the cycle busy_out falls
    assign start   = (state_q == IDLE) && trigger_in && !cool_q;
    assign above   = qval > thr_q;
    assign hit     = qual && above && (run_q == RUN_W'(CONFIRM_COUNT - 1));
    assign timeout = win_q == WIN_W'(WINDOW_CYCLES);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BLANK;
            BLANK:   if (win_q == WIN_W'(BLANK_CYCLES)) state_d = LISTEN;
            LISTEN:  if (hit || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            thr_q   <= '0;
            win_q   <= '0;
            run_q   <= '0;
            peak_q  <= '0;
            cool_q  <= 1'b0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            echo_q  <= hit;
            busy_q  <= state_d != IDLE;
            cool_q  <= (state_q == LISTEN) && (state_d == IDLE);
            if (start) begin
                thr_q  <= threshold_in;
                win_q  <= WIN_W'(1);
                run_q  <= '0;
                peak_q <= '0;
            end else if (state_q != IDLE) begin
                win_q <= win_q + WIN_W'(1);
            end
            if (qual) begin
                run_q <= above ? run_q + RUN_W'(1) : '0;
                if (qval > peak_q)
                    peak_q <= qval;
            end
        end
    end

    assign echo_detected = echo_q;
    assign peak_out      = peak_q;
    assign busy_out      = busy_q;

endmodule

// File: doc/echo_detector.md
# echo_detector

Front-end stage of the ranging path: converts the digitised ultrasonic receiver signal into the single-cycle `echo_detected` strobe that the time-of-flight stage timestamps. After each trigger it blanks transmitter ring-down, then declares an echo once the rectified sample magnitude exceeds a threshold for a run of consecutive samples. It also reports the peak magnitude seen in the listening window. It fires at most one echo per trigger and times out silently when no echo arrives.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 12: ADC sample width, offset-binary, midscale = 2^(SAMPLE_WIDTH-1).
- `BLANK_CYCLES`, 20000: clock cycles after trigger during which samples are ignored (200 µs at 100 MHz).
- `WINDOW_CYCLES`, 500000: total cycles from trigger to timeout, blanking included.
- `CONFIRM_COUNT`, 4: consecutive above-threshold valid samples required, ≥1.
- `ENV_SHIFT`, 3: envelope filter shift, used only with `ECHO_ENVELOPE_EN`.

Ports:
- `clk_in` in 1: system clock, 100 MHz.
- `rst_n_in` in 1: reset, asynchronous assert, active-low.
- `trigger_in` in 1: start of a ping, the same strobe that drives the time-of-flight stage.
- `sample_in` in SAMPLE_WIDTH: receiver ADC sample.
- `sample_valid_in` in 1: qualifies `sample_in`.
- `threshold_in` in SAMPLE_WIDTH-1: detection threshold on magnitude.
- `echo_detected` out 1: one-cycle echo strobe.
- `peak_out` out SAMPLE_WIDTH-1: maximum magnitude seen in LISTEN for the current or last ping.
- `busy_out` out 1: high in BLANK and LISTEN.

## Operation
- Magnitude is |sample_in − midscale|, saturated to SAMPLE_WIDTH-1 bits. Sample 0 maps to 2^(SAMPLE_WIDTH-1)−1.
- States and transitions:
  - IDLE: on `trigger_in`, go to BLANK.
  - BLANK: go to LISTEN when `BLANK_CYCLES` cycles have elapsed since the trigger.
  - LISTEN: on detection, go to IDLE. On timeout, go to IDLE.
- On trigger acceptance:
  - Latch `threshold_in`.
  - Clear the run counter, the window counter, `peak_out` and the envelope.
- `trigger_in` is ignored outside IDLE; there is no retrigger. This matches the time-of-flight stage, which ignores triggers while measuring.
- In BLANK, samples are discarded: no run counting, no peak update, no envelope update.
- In LISTEN, for each valid sample:
  - If magnitude > latched threshold (strict), increment the run counter. Otherwise clear it.
  - `peak_out` takes the max of itself and the magnitude.
- Cycles without `sample_valid_in` neither advance nor break a run.
- Detection occurs when the run counter reaches `CONFIRM_COUNT`. The FSM then returns to IDLE. `peak_out` holds its value until the next accepted trigger.
- Timeout occurs when the window counter reaches `WINDOW_CYCLES` with no detection. The FSM returns to IDLE and no strobe is issued.
- If detection and timeout fall in the same cycle, detection wins.
- Reset asserted mid-ping aborts immediately to IDLE. No strobe is issued.

## Timing
- Reset values: `echo_detected` = 0, `peak_out` = 0, `busy_out` = 0; state IDLE; all counters 0.
- `busy_out` rises on the cycle after the clock edge that accepts `trigger_in`.
- The window counter is 1 on the first BLANK cycle and increments every clock cycle, valid sample or not.
- BLANK spans window counts 1..BLANK_CYCLES. LISTEN begins at count BLANK_CYCLES+1.
- Detection latency: `echo_detected` is high for exactly one cycle. It asserts the cycle after the edge that registers the confirming sample. `busy_out` falls in the same cycle.
- `peak_out` updates one cycle after each valid LISTEN sample.
- The earliest possible strobe is BLANK_CYCLES + CONFIRM_COUNT + 1 cycles after trigger, for continuous valid samples with no envelope.
- Timeout: `busy_out` falls the cycle after the window counter reaches WINDOW_CYCLES.
- A trigger arriving in the same cycle that `busy_out` falls is ignored. A trigger arriving one cycle later is accepted.

## Configuration
- `ECHO_ENVELOPE_EN` defined:
  - The comparison and peak use a registered envelope: env ← env − (env >> ENV_SHIFT) + (mag >> ENV_SHIFT), updated on valid LISTEN samples.
  - This adds 1 cycle to detection latency.
- `ECHO_ENVELOPE_EN` undefined:
  - Raw magnitude is compared directly.
  - No envelope register is built.
  - `ENV_SHIFT` is unused.

## Test plan
- Reset and idle:
  - Hold `rst_n_in`=0, then release.
  - All outputs must be 0.
  - Samples at 0xFFF with no trigger must produce no strobe.
- Basic detection:
  - Setup: no envelope, threshold 500, BLANK 100, CONFIRM 4, valid every cycle.
  - Stimulus: trigger, then samples at 2048+600 from window count 101.
  - Required: one `echo_detected` pulse at trigger+105 cycles; `peak_out`=600; `busy_out` low from the same cycle.
- Blanking:
  - Stimulus: samples at magnitude 1000 only during counts 1..100, then 2048.
  - Required: no strobe; timeout at WINDOW_CYCLES; `peak_out`=0.
- Run break and threshold equality:
  - Stimulus: magnitudes 600, 600, 600, 500 (equal to threshold), then 600 ×4.
  - Required: strobe after the 8th LISTEN sample, not the 3rd or 4th.
  - Also: gaps in `sample_valid_in` inside a run must not delay the count beyond the valid samples.
- Retrigger and abort:
  - `trigger_in` pulses during LISTEN are ignored; the window is not restarted.
  - Asserting `rst_n_in` mid-LISTEN forces `busy_out`=0 asynchronously, with no strobe.
  - A new trigger after release is accepted.
- Envelope build:
  - Setup: build with `ECHO_ENVELOPE_EN`, ENV_SHIFT 3.
  - Stimulus: step the magnitude to 800 against threshold 500.
  - Required: detection only once the envelope exceeds 500 for 4 consecutive samples, matching the golden model cycle-exactly.
